// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with prescaler, wrap or saturate at 0..max_val,
// a one-cycle terminal-count pulse and a sticky limit-event flag.
module updown_mod_counter #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MODE     = 0,
    parameter int unsigned PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] max_val,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned PS_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0]  ps_q, ps_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             step;
    logic             term;

    // Step decision, next count and flag updates; load pre-empts stepping.
    always_comb begin
        ps_d    = ps_q;
        count_d = count_q;
        step    = 1'b0;
        term    = 1'b0;

        if (load) begin
            ps_d    = '0;
            count_d = (load_val > max_val) ? max_val : load_val;
        end else if (en) begin
            if (ps_q == PS_LAST) begin
                ps_d = '0;
                step = 1'b1;
            end else begin
                ps_d = ps_q + PS_W'(1);
            end
        end

        if (step) begin
            if (up) begin
                if (count_q >= max_val) begin
                    term    = 1'b1;
                    count_d = (MODE == 1) ? max_val : '0;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (count_q == '0) begin
                    term    = 1'b1;
                    count_d = (MODE == 1) ? '0 : max_val;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end

        tc_d = term;
        // Set wins over clear when both happen in one cycle.
        if (term) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ps_q    <= '0;
            count_q <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            ps_q    <= ps_d;
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign ovf   = ovf_q;
    assign zero  = (count_q == '0);

endmodule
